// File: rtl/fsic_io_serdes_pkg.sv
// Constants shared by the FSIC IO serdes transmit and receive halves.
// Holds the default clock ratio, phase-counter sizing and serial bit order.
package fsic_io_serdes_pkg;

    localparam int SERDES_CLK_RATIO = 4;
    localparam bit SERDES_LSB_FIRST = 1'b1;

    // Phase counter needs at least one bit even for the smallest legal ratio.
    function automatic int phase_width(input int ratio);
        return (ratio > 2) ? $clog2(ratio) : 1;
    endfunction

    localparam int SERDES_PHASE_W = phase_width(SERDES_CLK_RATIO);

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_RUN  = 1'b1
    } tx_state_e;

endpackage

// File: rtl/fsic_io_serdes_tx_if.sv
// Core-side and pad-side signals of the serdes transmitter.
// Handshake: txdata_in_valid qualifies txdata_in for one whole core period; there is no
// backpressure, the transmitter always accepts. txclk_en high marks serial_data_out as a live bit.
interface fsic_io_serdes_tx_if #(
    parameter int pCLK_RATIO  = 4,
    parameter int pWORD_CNT_W = 16
) ();
    logic                   txen;
    logic [pCLK_RATIO-1:0]  txdata_in;
    logic                   txdata_in_valid;
    logic                   serial_data_out;
    logic                   txclk_en;
    logic                   tx_load;
    logic                   tx_active;
    logic [pWORD_CNT_W-1:0] tx_word_cnt;

    modport slave (
        input  txen, txdata_in, txdata_in_valid,
        output serial_data_out, txclk_en, tx_load, tx_active, tx_word_cnt
    );

    modport master (
        output txen, txdata_in, txdata_in_valid,
        input  serial_data_out, txclk_en, tx_load, tx_active, tx_word_cnt
    );
endinterface

// File: rtl/fsic_io_serdes_tx_shifter.sv
// Shift register, phase counter and load decision for the serdes transmitter.
// next_bit is the value the top registers onto the pad at the coming edge.
module fsic_io_serdes_tx_shifter
    import fsic_io_serdes_pkg::*;
#(
    parameter int pCLK_RATIO = SERDES_CLK_RATIO
) (
    input  logic                  ioclk,
    input  logic                  rst_n,
    input  logic                  txen,
    input  logic                  tx_start,
    input  logic [pCLK_RATIO-1:0] txdata_in,
    input  logic                  txdata_in_valid,
    output logic                  load_now,
    output logic                  next_bit
);
    localparam int PW = phase_width(pCLK_RATIO);
    localparam logic [PW-1:0] LAST_PHASE = PW'(pCLK_RATIO - 1);

    logic [pCLK_RATIO-1:0] shreg_q;
    logic [pCLK_RATIO-1:0] word_eff;
    logic [PW-1:0]         phase_q;

    // A running link with no valid word still ships zeros to keep the far end in phase.
    always_comb begin
        word_eff = txdata_in_valid ? txdata_in : '0;
        load_now = txen && (tx_start ? (phase_q == LAST_PHASE) : txdata_in_valid);
        next_bit = 1'b0;
        if (load_now)
            next_bit = word_eff[0];
        else if (txen && tx_start)
            next_bit = shreg_q[0];
    end

    always_ff @(posedge ioclk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            phase_q <= LAST_PHASE;
        end else if (!txen) begin
            shreg_q <= '0;
            phase_q <= LAST_PHASE;
        end else if (load_now) begin
            shreg_q <= word_eff >> 1;
            phase_q <= '0;
        end else if (tx_start) begin
            shreg_q <= shreg_q >> 1;
            phase_q <= phase_q + PW'(1);
        end
    end

endmodule

// File: rtl/fsic_io_serdes_tx.sv
// FSIC IO serdes transmitter: serializes one parallel word per core period LSB first
// and produces the enable for the forwarded pad clock.
module fsic_io_serdes_tx
    import fsic_io_serdes_pkg::*;
#(
    parameter int pCLK_RATIO  = SERDES_CLK_RATIO,
    parameter int pWORD_CNT_W = 16
) (
    input  logic                ioclk,
    input  logic                axis_rst_n,
    fsic_io_serdes_tx_if.slave  bus
);
    tx_state_e              state_q, state_d;
    logic                   tx_start, tx_start_next;
    logic                   load_now, next_bit;
    logic                   serial_q, txclk_en_q, tx_load_q;
    logic [pWORD_CNT_W-1:0] word_cnt_q;

    always_comb begin
        state_d = state_q;
        if (!bus.txen)
            state_d = TX_IDLE;
        else if (state_q == TX_IDLE && bus.txdata_in_valid)
            state_d = TX_RUN;
        tx_start      = (state_q == TX_RUN);
        tx_start_next = (state_d == TX_RUN);
    end

    fsic_io_serdes_tx_shifter #(.pCLK_RATIO(pCLK_RATIO)) u_shifter (
        .ioclk           (ioclk),
        .rst_n           (axis_rst_n),
        .txen            (bus.txen),
        .tx_start        (tx_start),
        .txdata_in       (bus.txdata_in),
        .txdata_in_valid (bus.txdata_in_valid),
        .load_now        (load_now),
        .next_bit        (next_bit)
    );

    // txclk_en follows the next state so the far end gets an edge for bit0 of the first word.
    always_ff @(posedge ioclk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q    <= TX_IDLE;
            serial_q   <= 1'b0;
            txclk_en_q <= 1'b0;
            tx_load_q  <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            serial_q   <= bus.txen && next_bit;
            txclk_en_q <= tx_start_next;
            tx_load_q  <= load_now;
            if (load_now && bus.txdata_in_valid)
                word_cnt_q <= word_cnt_q + pWORD_CNT_W'(1);
        end
    end

    assign bus.serial_data_out = serial_q;
    assign bus.txclk_en        = txclk_en_q;
    assign bus.tx_load         = tx_load_q;
    assign bus.tx_active       = tx_start;
    assign bus.tx_word_cnt     = word_cnt_q;

endmodule
